// File: rtl/saph_col_unpremul.sv
`default_nettype none
// ============================================================================
// Module      : saph_col_unpremul
// Description : Converts one premultiplied ARGB8888 color to straight alpha.
//               Alpha 0 and 0xFF take a one-cycle fast path. Other alphas run
//               an 8-cycle restoring divide on all three channels in parallel.
// Revision    : 1.0 - initial release
// ============================================================================
module saph_col_unpremul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_col,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_col
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] C_LAST_ITER = 3'd7;

  state_t           r_state;
  logic [7:0]       r_alpha;
  logic [2:0]       r_cnt;
  logic [2:0]       r_clamp;
  logic [2:0][8:0]  r_rem;
  logic [2:0][7:0]  r_lo;     // low dividend byte, shifted out as quotient bits shift in
  logic [31:0]      r_out_col;

  logic [7:0]       w_in_a;
  logic [2:0]       w_clamp_init;
  logic [2:0][8:0]  w_rem_init;
  logic [2:0][7:0]  w_lo_init;
  logic [2:0][8:0]  w_rem_nxt;
  logic [2:0][7:0]  w_lo_nxt;
  logic [2:0][7:0]  w_res;

  assign w_in_a    = in_col[31:24];
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out_col   = r_out_col;

  // Channel 0 = b, 1 = g, 2 = r. The quotient is known to fit in 8 bits, so the
  // dividend's high byte is already below A and can seed the remainder directly,
  // leaving only 8 restoring steps for the low byte.
  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [7:0]  w_c;
    logic [15:0] w_dividend;
    logic [9:0]  w_trial;
    logic        w_ge;

    assign w_c             = in_col[8*i +: 8];
    assign w_dividend      = ({8'd0, w_c} * 16'd255) + {9'd0, w_in_a[7:1]};
    assign w_clamp_init[i] = (w_c >= w_in_a);
    assign w_rem_init[i]   = {1'b0, w_dividend[15:8]};
    assign w_lo_init[i]    = w_dividend[7:0];

    assign w_trial      = {r_rem[i], r_lo[i][7]};
    assign w_ge         = (w_trial >= {2'b00, r_alpha});
    assign w_rem_nxt[i] = w_ge ? 9'(w_trial - {2'b00, r_alpha}) : w_trial[8:0];
    assign w_lo_nxt[i]  = {r_lo[i][6:0], w_ge};
    assign w_res[i]     = r_clamp[i] ? 8'hFF : w_lo_nxt[i];
  end

  // Control FSM plus divider datapath; the result register only holds a value in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_alpha   <= 8'd0;
      r_cnt     <= 3'd0;
      r_clamp   <= 3'd0;
      r_rem     <= '0;
      r_lo      <= '0;
      r_out_col <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_alpha <= w_in_a;
            r_cnt   <= 3'd0;
            r_clamp <= w_clamp_init;
            r_rem   <= w_rem_init;
            r_lo    <= w_lo_init;
            if (w_in_a == 8'h00) begin
              r_state   <= ST_DONE;
              r_out_col <= 32'd0;
            end else if (w_in_a == 8'hFF) begin
              r_state   <= ST_DONE;
              r_out_col <= in_col;
            end else begin
              r_state <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          r_rem <= w_rem_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == C_LAST_ITER) begin
            r_state   <= ST_DONE;
            r_out_col <= {r_alpha, w_res};
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state   <= ST_IDLE;
            r_out_col <= 32'd0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_out_col <= 32'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_saph_col_unpremul.sv
`default_nettype none
// ============================================================================
// Module      : tb_saph_col_unpremul
// Description : Self-checking bench for saph_col_unpremul against an
//               arithmetic reference of the unpremultiply rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_saph_col_unpremul;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_col = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_col;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  saph_col_unpremul dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_col    (in_col),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Straight-alpha value of a premultiplied color, by plain integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [31:0] c);
    int a, cv, q;
    logic [31:0] res;
    a = int'(c[31:24]);
    if (a == 0) return 32'd0;
    if (a == 255) return c;
    res = {c[31:24], 24'd0};
    for (int ch = 0; ch < 3; ch++) begin
      cv = int'((c >> (8 * ch)) & 32'hFF);
      if (cv >= a) q = 255;
      else q = (cv * 255 + a / 2) / a;
      res = res | (32'(q) << (8 * ch));
    end
    return res;
  endfunction

  function automatic int ref_lat(input logic [31:0] c);
    if (c[31:24] == 8'h00 || c[31:24] == 8'hFF) return 0;
    return 8;
  endfunction

  // Offer one color at a negedge; lat counts edges after the accept edge until out_valid.
  task automatic run_op(input logic [31:0] col, input bit consume,
                        output logic [31:0] got, output int lat);
    in_valid = 1'b1;
    in_col   = col;
    @(negedge clk);
    in_valid = 1'b0;
    in_col   = $urandom;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    got = out_col;
    if (consume) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_col !== 32'd0) begin failures++; $display("FAIL reset_out_col: got %h expected 00000000", out_col); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_accept();
    logic [31:0] got;
    int lat;
    run_op(32'h80408000, 1'b1, got, lat);
    checks++;
    if (got !== 32'h8080FF00 || lat !== 8) begin
      failures++;
      $display("FAIL first_accept: got %h lat %0d expected 8080FF00 lat 8", got, lat);
    end
  endtask

  task automatic test_divide_vectors();
    logic [31:0] got;
    int lat;
    run_op(32'h03020100, 1'b1, got, lat);
    checks++;
    if (got !== 32'h03AA5500) begin failures++; $display("FAIL div_03020100: got %h expected 03AA5500", got); end
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL div_latency: got %0d expected 8", lat); end
    checks++;
    if (in_ready !== 1'b1 || out_col !== 32'd0) begin
      failures++;
      $display("FAIL div_release: in_ready %b out_col %h expected 1 00000000", in_ready, out_col);
    end
  endtask

  task automatic test_fast_path();
    logic [31:0] got;
    int lat;
    run_op(32'h00FF7F10, 1'b1, got, lat);
    checks++;
    if (got !== 32'h00000000 || lat !== 0) begin
      failures++;
      $display("FAIL fast_zero: got %h lat %0d expected 00000000 lat 0", got, lat);
    end
    run_op(32'hFF102030, 1'b1, got, lat);
    checks++;
    if (got !== 32'hFF102030 || lat !== 0) begin
      failures++;
      $display("FAIL fast_opaque: got %h lat %0d expected FF102030 lat 0", got, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got;
    int lat;
    run_op(32'h80408000, 1'b0, got, lat);
    checks++;
    if (got !== 32'h8080FF00) begin failures++; $display("FAIL bp_result: got %h expected 8080FF00", got); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom);
      in_col   = $urandom;
      @(negedge clk);
      checks++;
      if (out_col !== 32'h8080FF00 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold: out_col %h in_ready %b out_valid %b expected 8080FF00 0 1",
                 out_col, in_ready, out_valid);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_col !== 32'd0) begin
      failures++;
      $display("FAIL bp_release: in_ready %b out_valid %b out_col %h expected 1 0 00000000",
               in_ready, out_valid, out_col);
    end
  endtask

  task automatic test_reset_mid_div();
    bit seen_valid;
    in_valid = 1'b1;
    in_col   = 32'h80408000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_col !== 32'd0) begin
      failures++;
      $display("FAIL midreset_async: in_ready %b out_valid %b out_col %h expected 1 0 00000000",
               in_ready, out_valid, out_col);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_discard: out_valid_seen %b in_ready %b expected 0 1", seen_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] cols [3];
    logic [31:0] got;
    int lat, c0, period;
    cols[0] = 32'h00123456;
    cols[1] = 32'h7F3F7F00;
    cols[2] = 32'hFFABCDEF;
    for (int k = 0; k < 3; k++) begin
      c0 = cyc;
      run_op(cols[k], 1'b1, got, lat);
      period = cyc - c0;
      checks++;
      if (got !== ref_model(cols[k]) || period !== ref_lat(cols[k]) + 2) begin
        failures++;
        $display("FAIL b2b_%0d: got %h period %0d expected %h period %0d",
                 k, got, period, ref_model(cols[k]), ref_lat(cols[k]) + 2);
      end
    end
  endtask

  function automatic logic [7:0] pick_chan(input int a);
    case ($urandom_range(0, 3))
      0:       return 8'(a - 1);
      1:       return 8'(a);
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic test_random_sweep();
    logic [31:0] col, got, exp;
    int lat;
    for (int a = 1; a <= 254; a++) begin
      col = {8'(a), pick_chan(a), pick_chan(a), pick_chan(a)};
      exp = ref_model(col);
      run_op(col, 1'b1, got, lat);
      checks++;
      if (got !== exp || lat !== 8) begin
        failures++;
        $display("FAIL sweep_a%0d: in %h got %h lat %0d expected %h lat 8", a, col, got, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_accept();
    test_divide_vectors();
    test_fast_path();
    test_backpressure();
    test_reset_mid_div();
    test_back_to_back();
    test_random_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
